// File: rtl/cva6_icache_tag_pkg.sv
// Shared types and helpers for the instruction-cache tag controller.
// Holds the tag word layout, the sequencer states and the victim-select function.
package cva6_icache_tag_pkg;

  localparam int unsigned MaxTagWidth = 64;
  localparam int unsigned MaxWays     = 32;

  typedef struct packed {
    logic                   valid;
    logic [MaxTagWidth-1:0] tag;
  } tag_word_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_FLUSH,
    ST_IDLE
  } state_e;

  // Lowest invalid way wins; unused upper bits of way_valid must be tied high.
  function automatic int unsigned victim_index(input logic [MaxWays-1:0] way_valid,
                                               input int unsigned        rr_idx);
    int unsigned idx;
    idx = rr_idx;
    for (int i = MaxWays - 1; i >= 0; i--) begin
      if (!way_valid[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cva6_icache_victim_sel.sv
// Refill victim selection: lowest invalid way, else round-robin pointer.
// The choice is captured at each lookup response and held until the next one.
module cva6_icache_victim_sel
  import cva6_icache_tag_pkg::*;
#(
  parameter int unsigned WayCount = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rfl_gnt_i,
  input  logic                rsp_valid_i,
  input  logic [WayCount-1:0] way_valid_i,
  output logic [WayCount-1:0] victim_way_o
);

  localparam int unsigned RrWidth = $clog2(WayCount);

  logic [RrWidth-1:0]  rr_d, rr_q;
  logic [WayCount-1:0] victim_d, victim_q;
  logic [MaxWays-1:0]  valid_ext;
  int unsigned         sel_idx;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    rr_d      = rr_q;
    victim_d  = victim_q;
    valid_ext = '1;
    valid_ext[WayCount-1:0] = way_valid_i;
    sel_idx   = victim_index(valid_ext, int'(rr_q));

    if (rfl_gnt_i) begin
      rr_d = (rr_q == RrWidth'(WayCount - 1)) ? '0 : rr_q + RrWidth'(1);
    end
    if (rsp_valid_i) begin
      victim_d = WayCount'(1) << sel_idx;
    end
  end

  // NOTE: flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      victim_q <= WayCount'(1);
    end else begin
      rr_q     <= rr_d;
      victim_q <= victim_d;
    end
  end

  assign victim_way_o = victim_q;

endmodule

// File: rtl/cva6_icache_tag_ctrl.sv
// Tag SRAM sequencer/arbiter: post-reset invalidation sweep, flush > refill > lookup
// arbitration of the shared tag port, and one-cycle-later hit compare.
module cva6_icache_tag_ctrl
  import cva6_icache_tag_pkg::*;
#(
  parameter  int unsigned NumSets  = 256,
  parameter  int unsigned WayCount = 4,
  parameter  int unsigned TagWidth = 44,
  localparam int unsigned SetWidth = $clog2(NumSets)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  output logic                             flush_busy_o,
  input  logic                             lkp_req_i,
  output logic                             lkp_gnt_o,
  input  logic [SetWidth-1:0]              lkp_set_i,
  input  logic [TagWidth-1:0]              lkp_tag_i,
  output logic                             lkp_rvalid_o,
  output logic                             lkp_hit_o,
  output logic [WayCount-1:0]              lkp_hit_way_o,
  output logic                             lkp_multi_hit_o,
  output logic [WayCount-1:0]              victim_way_o,
  input  logic                             rfl_req_i,
  output logic                             rfl_gnt_o,
  input  logic [SetWidth-1:0]              rfl_set_i,
  input  logic [TagWidth-1:0]              rfl_tag_i,
  input  logic [WayCount-1:0]              rfl_way_i,
  output logic [WayCount-1:0]              tag_req_o,
  output logic                             tag_we_o,
  output logic [SetWidth-1:0]              tag_addr_o,
  output logic [TagWidth:0]                tag_wdata_o,
  input  logic [WayCount*(TagWidth+1)-1:0] tag_rdata_i
);

  localparam int unsigned WordWidth = TagWidth + 1;
  localparam int unsigned CntWidth  = $clog2(WayCount + 1);

  state_e              state_d, state_q;
  logic [SetWidth-1:0] cnt_d, cnt_q;
  logic                lkp_pend_d, lkp_pend_q;
  logic [TagWidth-1:0] lkp_tag_d, lkp_tag_q;

  tag_word_t           rd_word [WayCount];
  logic [WayCount-1:0] hit, way_valid;
  logic [CntWidth-1:0] hit_cnt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lkp_pend_d  = 1'b0;
    lkp_tag_d   = lkp_tag_q;
    lkp_gnt_o   = 1'b0;
    rfl_gnt_o   = 1'b0;
    tag_req_o   = '0;
    tag_we_o    = 1'b0;
    tag_addr_o  = '0;
    tag_wdata_o = '0;

    unique case (state_q)
      ST_INIT: begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
      ST_FLUSH: begin
        tag_req_o  = '1;
        tag_we_o   = 1'b1;
        tag_addr_o = cnt_q;
        cnt_d      = cnt_q + SetWidth'(1);
        if (cnt_q == SetWidth'(NumSets - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (flush_i) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (rfl_req_i) begin
          rfl_gnt_o   = 1'b1;
          tag_req_o   = rfl_way_i;
          tag_we_o    = 1'b1;
          tag_addr_o  = rfl_set_i;
          tag_wdata_o = {1'b1, rfl_tag_i};
        end else if (lkp_req_i) begin
          lkp_gnt_o  = 1'b1;
          tag_req_o  = '1;
          tag_addr_o = lkp_set_i;
          lkp_pend_d = 1'b1;
          lkp_tag_d  = lkp_tag_i;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      lkp_pend_q <= 1'b0;
      lkp_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lkp_pend_q <= lkp_pend_d;
      lkp_tag_q  <= lkp_tag_d;
    end
  end

  // Read data belongs to the lookup granted last cycle; compare against its saved tag.
  always_comb begin
    rd_word   = '{default: '0};
    hit       = '0;
    way_valid = '0;
    hit_cnt   = '0;
    for (int w = 0; w < WayCount; w++) begin
      rd_word[w].valid = tag_rdata_i[w*WordWidth + TagWidth];
      rd_word[w].tag   = MaxTagWidth'(tag_rdata_i[w*WordWidth +: TagWidth]);
      way_valid[w]     = rd_word[w].valid;
      hit[w]           = rd_word[w].valid && (rd_word[w].tag == MaxTagWidth'(lkp_tag_q));
      hit_cnt          = hit_cnt + CntWidth'(hit[w]);
    end
  end

  assign flush_busy_o    = (state_q != ST_IDLE);
  assign lkp_rvalid_o    = lkp_pend_q;
  assign lkp_hit_o       = lkp_pend_q && (|hit);
  assign lkp_hit_way_o   = lkp_pend_q ? hit : '0;
  assign lkp_multi_hit_o = lkp_pend_q && (hit_cnt > CntWidth'(1));

  cva6_icache_victim_sel #(
    .WayCount(WayCount)
  ) u_victim_sel (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rfl_gnt_i   (rfl_gnt_o),
    .rsp_valid_i (lkp_pend_q),
    .way_valid_i (way_valid),
    .victim_way_o(victim_way_o)
  );

endmodule

// File: tb/tb_cva6_icache_tag_ctrl.sv
// Bench for cva6_icache_tag_ctrl: directed stimulus with a behavioural tag SRAM,
// lookup responses checked by a queue-driven monitor.
module tb_cva6_icache_tag_ctrl;

  localparam int unsigned NumSets  = 8;
  localparam int unsigned WayCount = 4;
  localparam int unsigned TagWidth = 8;
  localparam int unsigned SetWidth = 3;
  localparam int unsigned WordW    = TagWidth + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic                      flush_i = 1'b0, flush_busy;
  logic                      lkp_req = 1'b0, lkp_gnt;
  logic [SetWidth-1:0]       lkp_set = '0;
  logic [TagWidth-1:0]       lkp_tag = '0;
  logic                      lkp_rvalid, lkp_hit, lkp_multi;
  logic [WayCount-1:0]       lkp_hit_way, victim_way;
  logic                      rfl_req = 1'b0, rfl_gnt;
  logic [SetWidth-1:0]       rfl_set = '0;
  logic [TagWidth-1:0]       rfl_tag = '0;
  logic [WayCount-1:0]       rfl_way = '0;
  logic [WayCount-1:0]       tag_req;
  logic                      tag_we;
  logic [SetWidth-1:0]       tag_addr;
  logic [TagWidth:0]         tag_wdata;
  logic [WayCount*WordW-1:0] tag_rdata = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic                hit;
    logic [WayCount-1:0] way;
    logic                multi;
    logic [WayCount-1:0] victim;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  cva6_icache_tag_ctrl #(
    .NumSets (NumSets),
    .WayCount(WayCount),
    .TagWidth(TagWidth)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush_i),
    .flush_busy_o   (flush_busy),
    .lkp_req_i      (lkp_req),
    .lkp_gnt_o      (lkp_gnt),
    .lkp_set_i      (lkp_set),
    .lkp_tag_i      (lkp_tag),
    .lkp_rvalid_o   (lkp_rvalid),
    .lkp_hit_o      (lkp_hit),
    .lkp_hit_way_o  (lkp_hit_way),
    .lkp_multi_hit_o(lkp_multi),
    .victim_way_o   (victim_way),
    .rfl_req_i      (rfl_req),
    .rfl_gnt_o      (rfl_gnt),
    .rfl_set_i      (rfl_set),
    .rfl_tag_i      (rfl_tag),
    .rfl_way_i      (rfl_way),
    .tag_req_o      (tag_req),
    .tag_we_o       (tag_we),
    .tag_addr_o     (tag_addr),
    .tag_wdata_o    (tag_wdata),
    .tag_rdata_i    (tag_rdata)
  );

  // Behavioural per-way tag SRAM with one-cycle read latency.
  logic [WordW-1:0] mem [WayCount][NumSets];
  always @(posedge clk) begin
    for (int w = 0; w < WayCount; w++) begin
      if (tag_req[w]) begin
        if (tag_we) mem[w][tag_addr] <= tag_wdata;
        else        tag_rdata[w*WordW +: WordW] <= mem[w][tag_addr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation on every lookup response; victim is checked one cycle later.
  initial begin
    exp_t             e;
    logic             vic_pend = 1'b0;
    logic [WayCount-1:0] vic_exp = '0;
    forever begin
      @(negedge clk);
      if (vic_pend) begin
        check("victim_way", victim_way, vic_exp);
        vic_pend = 1'b0;
      end
      if (lkp_rvalid) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_rvalid: got rvalid=1 expected no response at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("lkp_hit", lkp_hit, e.hit);
          check("lkp_hit_way", lkp_hit_way, e.way);
          check("lkp_multi_hit", lkp_multi, e.multi);
          vic_pend = 1'b1;
          vic_exp  = e.victim;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    flush_i = 1'b0;
    lkp_req = 1'b0;
    rfl_req = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},   flush_busy, 1'b1);
    check({tag, "_gnts"},   {lkp_gnt, rfl_gnt}, 2'b00);
    check({tag, "_rsp"},    {lkp_rvalid, lkp_hit, lkp_multi}, 3'b000);
    check({tag, "_req_we"}, {tag_req, tag_we}, 5'b0);
    check({tag, "_addr"},   tag_addr, 3'd0);
    check({tag, "_wdata"},  tag_wdata, 9'd0);
    check({tag, "_victim"}, victim_way, 4'b0001);
  endtask

  // Starts just after a posedge; checks INIT (optional) then the 8 sweep writes.
  task automatic sweep(input bit with_init, input int abort_at);
    if (with_init) begin
      @(negedge clk);
      check("init_busy", flush_busy, 1'b1);
      check("init_no_access", {tag_req, tag_we}, 5'b0);
      check("init_no_gnt", {lkp_gnt, rfl_gnt}, 2'b00);
    end
    for (int a = 0; a < NumSets; a++) begin
      @(negedge clk);
      check("sweep_req", tag_req, 4'b1111);
      check("sweep_we", tag_we, 1'b1);
      check("sweep_addr", tag_addr, 64'(a));
      check("sweep_wdata", tag_wdata, 9'd0);
      check("sweep_busy", flush_busy, 1'b1);
      check("sweep_no_gnt", {lkp_gnt, rfl_gnt}, 2'b00);
      if (a == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_sweep_rst");
        idle_inputs();
        return;
      end
      @(posedge clk);
      #1;
      flush_i = (a == 2);
    end
    idle_inputs();
    @(negedge clk);
    check("sweep_done_busy", flush_busy, 1'b0);
    check("sweep_done_idle", {tag_req, tag_we}, 5'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_refill(input logic [2:0] set, input logic [7:0] tag,
                           input logic [3:0] way, input bit with_lkp);
    rfl_req = 1'b1; rfl_set = set; rfl_tag = tag; rfl_way = way;
    lkp_req = with_lkp; lkp_set = set; lkp_tag = tag;
    @(negedge clk);
    check("rfl_gnt", {rfl_gnt, lkp_gnt}, 2'b10);
    check("rfl_req_we", {tag_req, tag_we}, {way, 1'b1});
    check("rfl_addr", tag_addr, set);
    check("rfl_wdata", tag_wdata, {1'b1, tag});
    @(posedge clk);
    #1;
    rfl_req = 1'b0;
    lkp_req = 1'b0;
  endtask

  task automatic do_lookup(input logic [2:0] set, input logic [7:0] tag, input bit exp_resp,
                           input logic hit, input logic [3:0] way, input logic multi,
                           input logic [3:0] victim);
    if (exp_resp) exp_q.push_back('{hit: hit, way: way, multi: multi, victim: victim});
    lkp_req = 1'b1; lkp_set = set; lkp_tag = tag;
    @(negedge clk);
    check("lkp_gnt", {lkp_gnt, rfl_gnt}, 2'b10);
    check("lkp_req_we", {tag_req, tag_we}, 5'b11110);
    check("lkp_addr", tag_addr, set);
    @(posedge clk);
    #1;
    lkp_req = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset_vals("reset");

    // Post-reset sweep with requests held and a flush pulse that must be ignored.
    rfl_req = 1'b1; lkp_req = 1'b1; rfl_way = 4'b1111;
    release_reset();
    sweep(1'b1, -1);

    // Refill then hit / miss, issued back to back.
    do_refill(3'd3, 8'h5A, 4'b0100, 1'b0);
    do_lookup(3'd3, 8'h5A, 1'b1, 1'b1, 4'b0100, 1'b0, 4'b0001);
    do_lookup(3'd3, 8'h5B, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);

    // Refill beats a simultaneous lookup; the lookup must not respond.
    do_refill(3'd2, 8'h11, 4'b0001, 1'b1);
    do_refill(3'd2, 8'h22, 4'b0010, 1'b0);
    do_lookup(3'd2, 8'h22, 1'b1, 1'b1, 4'b0010, 1'b0, 4'b0100);

    // Same tag in two ways raises the multi-hit flag.
    do_refill(3'd5, 8'h77, 4'b0001, 1'b0);
    do_refill(3'd5, 8'h77, 4'b0100, 1'b0);
    do_lookup(3'd5, 8'h77, 1'b1, 1'b1, 4'b0101, 1'b1, 4'b0010);

    do_refill(3'd7, 8'hA1, 4'b0001, 1'b0);
    do_refill(3'd7, 8'hA2, 4'b0010, 1'b0);
    do_refill(3'd7, 8'hA3, 4'b0100, 1'b0);
    do_lookup(3'd7, 8'hA2, 1'b1, 1'b1, 4'b0010, 1'b0, 4'b1000);

    // All ways valid: round-robin pointer decides (8 refills so far -> rr=0, then 12 -> 0).
    do_refill(3'd6, 8'h10, 4'b0001, 1'b0);
    do_refill(3'd6, 8'h20, 4'b0010, 1'b0);
    do_refill(3'd6, 8'h30, 4'b0100, 1'b0);
    do_refill(3'd6, 8'h40, 4'b1000, 1'b0);
    do_lookup(3'd6, 8'h30, 1'b1, 1'b1, 4'b0100, 1'b0, 4'b0001);
    do_refill(3'd7, 8'hA4, 4'b1000, 1'b0);
    do_lookup(3'd6, 8'h40, 1'b1, 1'b1, 4'b1000, 1'b0, 4'b0010);

    // Lookup followed by flush with all requests high: result still returns, no grants.
    do_lookup(3'd3, 8'h5A, 1'b1, 1'b1, 4'b0100, 1'b0, 4'b0001);
    flush_i = 1'b1; rfl_req = 1'b1; lkp_req = 1'b1;
    @(negedge clk);
    check("prio_flush_no_gnt", {lkp_gnt, rfl_gnt}, 2'b00);
    check("prio_flush_no_access", {tag_req, tag_we}, 5'b0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    sweep(1'b0, -1);
    do_lookup(3'd3, 8'h5A, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001);

    // Reset in the response cycle of a lookup drops the result.
    do_lookup(3'd3, 8'h5A, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_lookup_rst");
    release_reset();
    sweep(1'b1, 4);
    release_reset();
    sweep(1'b1, -1);

    // Round-robin pointer restarts at 0 after reset.
    do_refill(3'd1, 8'h01, 4'b0001, 1'b0);
    do_refill(3'd1, 8'h02, 4'b0010, 1'b0);
    do_refill(3'd1, 8'h03, 4'b0100, 1'b0);
    do_refill(3'd1, 8'h04, 4'b1000, 1'b0);
    do_lookup(3'd1, 8'h03, 1'b1, 1'b1, 4'b0100, 1'b0, 4'b0001);
    do_refill(3'd1, 8'h05, 4'b0001, 1'b0);
    do_lookup(3'd1, 8'h01, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0010);

    repeat (3) @(posedge clk);
    check("responses_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cva6_icache_tag_ctrl.md
# cva6_icache_tag_ctrl

Sequencer and arbiter for the per-way instruction-cache tag SRAMs. Each way stores `{valid, tag}`. The block shares the single tag port between three users: the fetch lookup path, the miss-refill write path and a full-cache invalidation sweep, with the sweep running automatically after reset. It also compares tags to produce hit/way results one cycle after each lookup, and selects the refill victim way.

## Interface
Parameters:
- `NumSets`, 256: sets per way; `SetWidth = $clog2(NumSets)`.
- `WayCount`, 4: number of ways, ≥2.
- `TagWidth`, 44: tag bits; each SRAM word is `TagWidth+1` bits, MSB = valid.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: asynchronous active-low reset.
- `flush_i`  in  1: single-cycle pulse requesting invalidation of all sets.
- `flush_busy_o`  out  1: sweep in progress.
- `lkp_req_i`  in  1: lookup request.
- `lkp_gnt_o`  out  1: lookup accepted this cycle.
- `lkp_set_i`  in  SetWidth: lookup set index.
- `lkp_tag_i`  in  TagWidth: tag to compare, sampled at grant.
- `lkp_rvalid_o`  out  1: lookup result valid.
- `lkp_hit_o`  out  1: any way hit.
- `lkp_hit_way_o`  out  WayCount: one-hot hit vector.
- `lkp_multi_hit_o`  out  1: more than one way hit; this is an error flag.
- `victim_way_o`  out  WayCount: one-hot refill victim derived from the last lookup result.
- `rfl_req_i`  in  1: refill tag write request.
- `rfl_gnt_o`  out  1: refill write performed this cycle.
- `rfl_set_i`  in  SetWidth: refill set.
- `rfl_tag_i`  in  TagWidth: refill tag.
- `rfl_way_i`  in  WayCount: one-hot way to write.
- `tag_req_o`  out  WayCount: per-way SRAM request.
- `tag_we_o`  out  1: SRAM write enable.
- `tag_addr_o`  out  SetWidth: SRAM address.
- `tag_wdata_o`  out  TagWidth+1: `{valid, tag}` write word.
- `tag_rdata_i`  in  WayCount×(TagWidth+1): per-way read data, one-cycle latency.

## Operation
FSM states are INIT, FLUSH and IDLE. The reset state is INIT.

- **INIT**: one cycle with no SRAM access. Then go to FLUSH with `cnt=0`.
- **FLUSH**:
  - Each cycle, assert all `tag_req_o`, set `tag_we_o=1`, `tag_addr_o=cnt` and `tag_wdata_o=0`, then increment `cnt`.
  - After writing `cnt==NumSets-1`, go to IDLE.
  - `flush_i` during INIT or FLUSH is ignored; the sweep already covers every set.
- **IDLE** uses fixed priority flush > refill > lookup:
  - `flush_i=1`: go to FLUSH with `cnt=0`. No grants in that cycle.
  - Otherwise `rfl_req_i=1`: `rfl_gnt_o=1`, `tag_req_o=rfl_way_i`, `tag_we_o=1`, `tag_addr_o=rfl_set_i`, `tag_wdata_o={1'b1,rfl_tag_i}`.
  - Otherwise `lkp_req_i=1`: `lkp_gnt_o=1`, all `tag_req_o=1`, `tag_we_o=0`, `tag_addr_o=lkp_set_i`. Register `lkp_tag_i` and a pending flag.
- Grants are combinational in the request cycle. A requester not granted holds its request and payload stable.
- **Compare**: in the cycle after a lookup grant, `lkp_rvalid_o=1`. Per way, `hit[w] = rdata[w].valid & (rdata[w].tag == saved_tag)`.
  - `lkp_hit_o = |hit`.
  - `lkp_multi_hit_o = popcount(hit) > 1`.
- **Victim**:
  - `victim_way_o` is registered at each lookup response and holds until the next one.
  - Value is the lowest-index invalid way if any way is invalid; otherwise one-hot of the round-robin pointer `rr`.
  - `rr` increments modulo `WayCount` on every refill grant.
- **Flush vs. pending lookup**: a lookup granted in the cycle before a flush still returns its result normally.

## Timing
- Reset values:
  - `flush_busy_o=1`.
  - `lkp_gnt_o`, `rfl_gnt_o`, `lkp_rvalid_o`, `lkp_hit_o`, `lkp_multi_hit_o`, `tag_req_o`, `tag_we_o` all 0.
  - `tag_addr_o=0`, `tag_wdata_o=0`.
  - `victim_way_o` = one-hot way 0; `rr=0`.
- `flush_busy_o` is 1 in INIT and FLUSH, 0 in IDLE. It drops in the cycle after the last sweep write.
- Sweep length is exactly `NumSets` write cycles plus 1 INIT cycle after reset.
- Lookup latency is 1 cycle from grant to `lkp_rvalid_o`. Back-to-back lookups sustain 1 per cycle.
- Refill and lookup can never occur in the same cycle. A refill grant produces no `lkp_rvalid_o` in the next cycle.
- `rst_ni` asserted mid-sweep or mid-lookup: all state clears immediately, any pending result is dropped, and the block restarts from INIT.

## Structure
- Shared package `cva6_icache_tag_pkg` holds:
  - the `tag_word_t` struct `{valid, tag}`;
  - the FSM state enum;
  - the victim-select function.
- Sub-module `cva6_icache_victim_sel` contains the lowest-invalid priority encoder, the round-robin fallback and the `rr` register.
- Everything else stays in the top module.

## Test plan
Use `NumSets=8`, `WayCount=4`, `TagWidth=8` throughout.
- **Reset sweep**: release reset → 1 idle cycle, then 8 writes to addresses 0..7 with `wdata=0` and `tag_req_o=4'b1111`. `flush_busy_o` falls after address 7. Requests during the sweep get no grant.
- **Refill then hit**: refill set 3, tag `0x5A`, way `4'b0100` → next lookup of set 3 / `0x5A` gives `rvalid=1`, `hit=1`, `hit_way=4'b0100`. A lookup with `0x5B` gives `hit=0`.
- **Priority**: `flush_i`, `rfl_req_i` and `lkp_req_i` all high in IDLE → no grants and the sweep starts. `rfl_req_i` with `lkp_req_i` → only `rfl_gnt_o`.
- **Victim**:
  - Ways 0 and 1 valid in set 2 → lookup gives `victim=4'b0100`.
  - All four ways valid → `victim=4'b0001`; after 1 refill grant, `victim=4'b0010` on the next all-valid lookup.
- **Multi-hit**: refill the same tag into ways 0 and 2 of set 5 → lookup gives `hit_way=4'b0101`, `multi_hit=1`.
- **Reset mid-flush**: assert `rst_ni=0` at sweep address 4 → outputs return to reset values and the sweep restarts from address 0.
